// File: rtl/psram_resp_if.sv
// rtl/psram_resp_if.sv - octal-DDR PSRAM pin bundle between host initiator and responder
interface psram_resp_if;
  logic       psram_sck_i;
  logic       psram_ce_i;
  logic [7:0] psram_io_i;
  logic [7:0] psram_io_o;
  logic [7:0] psram_io_en_o;
  logic       psram_dqs_i;
  logic       psram_dqs_o;
  logic       psram_dqs_en_o;
  logic       busy_o;
  logic       err_o;

  modport master (
    output psram_sck_i, psram_ce_i, psram_io_i, psram_dqs_i,
    input  psram_io_o, psram_io_en_o, psram_dqs_o, psram_dqs_en_o, busy_o, err_o
  );

  modport slave (
    input  psram_sck_i, psram_ce_i, psram_io_i, psram_dqs_i,
    output psram_io_o, psram_io_en_o, psram_dqs_o, psram_dqs_en_o, busy_o, err_o
  );
endinterface

// File: rtl/psram_resp.sv
// rtl/psram_resp.sv - octal-DDR PSRAM responder with byte array and eight mode registers
module psram_resp #(
  parameter int          ADDR_WIDTH = 12,
  parameter logic [7:0]  CMD_WR     = 8'hA0,
  parameter logic [7:0]  CMD_RD     = 8'h20,
  parameter logic [7:0]  CMD_MRW    = 8'hC0,
  parameter logic [7:0]  CMD_MRR    = 8'h40,
  parameter logic [7:0]  CMD_RST    = 8'hFF,
  parameter logic [63:0] MR_RST     = 64'h0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  psram_resp_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_LATN, S_WDATA, S_RDATA, S_HOLD
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;

  logic                    r_sck, r_sck_d, r_ce, r_ce_d, r_dqs_in;
  logic [7:0]              r_io_in;
  logic [7:0]              r_cmd;
  logic [1:0]              r_cnt;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [7:0]              r_lat;
  logic [7:0]              r_mr [8];
  logic                    r_dqs_o;
  logic                    r_err;
  logic [7:0]              r_mem [2**ADDR_WIDTH];

  logic w_evt, w_rise, w_ce_fall, w_rd_act;
  logic w_cmd_ld, w_cnt_inc, w_addr_sh, w_lat_ld, w_lat_dec, w_addr_inc;
  logic w_mem_we, w_mr_we, w_mr_rst, w_err, w_dqs_tog;
  logic [7:0] w_lat_val;
  logic [7:0] w_rd_byte;

  // Both SCK edges are events; IO/DQS come from the same register stage as the edge.
  assign w_evt     = r_sck ^ r_sck_d;
  assign w_rise    = r_sck & ~r_sck_d;
  assign w_ce_fall = r_ce_d & ~r_ce;
  assign w_lat_val = (r_cmd == CMD_WR) ? r_mr[4] : r_mr[0];

  // Input synchronisation stage and edge-detect delay copies
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sck    <= 1'b0;
      r_sck_d  <= 1'b0;
      r_ce     <= 1'b0;
      r_ce_d   <= 1'b0;
      r_io_in  <= 8'h00;
      r_dqs_in <= 1'b0;
    end else begin
      r_sck    <= bus.psram_sck_i;
      r_sck_d  <= r_sck;
      r_ce     <= bus.psram_ce_i;
      r_ce_d   <= r_ce;
      r_io_in  <= bus.psram_io_i;
      r_dqs_in <= bus.psram_dqs_i;
    end
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode and per-event datapath strobes; ce high overrides everything
  always_comb begin
    w_state_nxt = r_state;
    w_cmd_ld    = 1'b0;
    w_cnt_inc   = 1'b0;
    w_addr_sh   = 1'b0;
    w_lat_ld    = 1'b0;
    w_lat_dec   = 1'b0;
    w_addr_inc  = 1'b0;
    w_mem_we    = 1'b0;
    w_mr_we     = 1'b0;
    w_mr_rst    = 1'b0;
    w_err       = 1'b0;
    w_dqs_tog   = 1'b0;
    if (r_ce) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (w_ce_fall) w_state_nxt = S_CMD;
        S_CMD: if (w_evt) begin
          w_cnt_inc = 1'b1;
          if (r_cnt == 2'd0) w_cmd_ld = 1'b1;
          else               w_state_nxt = S_ADDR;
        end
        S_ADDR: if (w_evt) begin
          w_addr_sh = 1'b1;
          w_cnt_inc = 1'b1;
          if (r_cnt == 2'd3) begin
            if (r_cmd == CMD_RST) begin
              w_mr_rst    = 1'b1;
              w_state_nxt = S_HOLD;
            end else if (r_cmd == CMD_MRW) begin
              w_state_nxt = S_WDATA;
            end else if (r_cmd == CMD_WR || r_cmd == CMD_RD || r_cmd == CMD_MRR) begin
              w_lat_ld    = 1'b1;
              w_state_nxt = S_LATN;
            end else begin
              w_err       = 1'b1;
              w_state_nxt = S_HOLD;
            end
          end
        end
        // Latency 0 and 1 both leave on the very next rising edge
        S_LATN: if (w_rise) begin
          if (r_lat <= 8'd1) w_state_nxt = (r_cmd == CMD_WR) ? S_WDATA : S_RDATA;
          else               w_lat_dec   = 1'b1;
        end
        S_WDATA: if (w_evt) begin
          w_addr_inc = 1'b1;
          if (r_cmd == CMD_MRW) begin
            w_mr_we     = r_dqs_in;
            w_state_nxt = S_HOLD;
          end else begin
            w_mem_we    = r_dqs_in;
          end
        end
        // MRR keeps presenting the same register, so its address never moves
        S_RDATA: if (w_evt) begin
          w_dqs_tog  = 1'b1;
          w_addr_inc = (r_cmd != CMD_MRR);
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // Command, address, latency, mode-register and strobe bookkeeping
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cmd   <= 8'h00;
      r_cnt   <= 2'd0;
      r_addr  <= '0;
      r_lat   <= 8'h00;
      r_dqs_o <= 1'b0;
      r_err   <= 1'b0;
      for (int i = 0; i < 8; i++) r_mr[i] <= MR_RST[8*i +: 8];
    end else begin
      r_err <= w_err;
      if (w_cmd_ld) r_cmd <= r_io_in;
      if (w_state_nxt != r_state) r_cnt <= 2'd0;
      else if (w_cnt_inc)         r_cnt <= r_cnt + 2'd1;
      if (w_addr_sh)       r_addr <= {r_addr[ADDR_WIDTH-9:0], r_io_in};
      else if (w_addr_inc) r_addr <= r_addr + 1'b1;
      if (w_lat_ld)       r_lat <= w_lat_val;
      else if (w_lat_dec) r_lat <= r_lat - 8'd1;
      if (r_state != S_RDATA) r_dqs_o <= 1'b0;
      else if (w_dqs_tog)     r_dqs_o <= ~r_dqs_o;
      if (w_mr_rst) begin
        for (int i = 0; i < 8; i++) r_mr[i] <= MR_RST[8*i +: 8];
      end else if (w_mr_we) begin
        r_mr[r_addr[2:0]] <= r_io_in;
      end
    end
  end

  // Array write port; contents survive reset
  always_ff @(posedge clk_i) begin
    if (w_mem_we) r_mem[r_addr] <= r_io_in;
  end

  // Output drive: disabled the same cycle registered ce goes high
  assign w_rd_act  = (r_state == S_RDATA) && !r_ce;
  assign w_rd_byte = (r_cmd == CMD_MRR) ? r_mr[r_addr[2:0]] : r_mem[r_addr];

  assign bus.psram_io_o     = w_rd_act ? w_rd_byte : 8'h00;
  assign bus.psram_io_en_o  = {8{w_rd_act}};
  assign bus.psram_dqs_o    = r_dqs_o & w_rd_act;
  assign bus.psram_dqs_en_o = w_rd_act;
  assign bus.busy_o         = (r_state != S_IDLE);
  assign bus.err_o          = r_err;

endmodule

// File: tb/tb_psram_resp.sv
// tb/tb_psram_resp.sv - randomized self-checking bench for psram_resp against a byte-level model
module tb_psram_resp;
  localparam logic [7:0] C_WR  = 8'hA0;
  localparam logic [7:0] C_RD  = 8'h20;
  localparam logic [7:0] C_MRW = 8'hC0;
  localparam logic [7:0] C_MRR = 8'h40;
  localparam logic [7:0] C_RST = 8'hFF;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  psram_resp_if bus();

  psram_resp dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int err_cnt = 0;

  logic [7:0] mem_m   [4096];
  bit         mvalid  [4096];
  logic [7:0] mr_m    [8];
  logic [7:0] wdat    [16];
  logic       wmsk    [16];

  always @(negedge clk_i) if (bus.err_o === 1'b1) err_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tog(input logic [7:0] d, input logic m);
    bus.psram_io_i  = d;
    bus.psram_dqs_i = m;
    bus.psram_sck_i = ~bus.psram_sck_i;
    repeat (4) @(negedge clk_i);
  endtask

  task automatic start(input logic [7:0] cmd, input logic [31:0] a);
    bus.psram_ce_i = 1'b0;
    repeat (3) @(negedge clk_i);
    tog(cmd, 1'b0);
    tog(cmd, 1'b0);
    tog(a[31:24], 1'b0);
    tog(a[23:16], 1'b0);
    tog(a[15:8], 1'b0);
    tog(a[7:0], 1'b0);
  endtask

  // Host waits max(L,1) rising edges; the rise that ends latency leaves sck high
  task automatic lat(input logic [7:0] l, input bit rd);
    int n;
    n = (l == 8'd0) ? 1 : int'(l);
    for (int i = 1; i <= n; i++) begin
      tog(8'h00, 1'b0);
      if (i < n) begin
        if (rd) chk("lat_io_en", {24'h0, bus.psram_io_en_o}, 32'h0);
        tog(8'h00, 1'b0);
      end
    end
  endtask

  task automatic stop(input bit chk_busy);
    bus.psram_ce_i = 1'b1;
    @(negedge clk_i);
    if (chk_busy) chk("busy_1clk", {31'h0, bus.busy_o}, 32'h1);
    @(negedge clk_i);
    if (chk_busy) chk("busy_2clk", {31'h0, bus.busy_o}, 32'h0);
    bus.psram_sck_i = 1'b0;
    repeat (4) @(negedge clk_i);
  endtask

  task automatic wr(input logic [11:0] a, input int n, input bit early);
    logic [11:0] p;
    p = a;
    start(C_WR, {20'h0, a});
    lat(mr_m[4], 1'b0);
    for (int k = 0; k < n; k++) begin
      tog(wdat[k], wmsk[k]);
      if (wmsk[k]) begin
        mem_m[p]  = wdat[k];
        mvalid[p] = 1'b1;
      end
      p = p + 12'd1;
    end
    stop(early);
  endtask

  task automatic rd(input logic [7:0] cmd, input logic [11:0] a, input int n);
    logic [11:0] p;
    p = a;
    start(cmd, {20'h0, a});
    lat(mr_m[0], 1'b1);
    for (int k = 0; k < n; k++) begin
      if (cmd == C_MRR) chk("mrr_byte", {24'h0, bus.psram_io_o}, {24'h0, mr_m[p[2:0]]});
      else if (mvalid[p]) chk("rd_byte", {24'h0, bus.psram_io_o}, {24'h0, mem_m[p]});
      chk("rd_dqs", {31'h0, bus.psram_dqs_o}, k % 2);
      chk("rd_io_en", {24'h0, bus.psram_io_en_o}, 32'hFF);
      tog(8'h00, 1'b0);
      if (cmd != C_MRR) p = p + 12'd1;
    end
    stop(1'b0);
  endtask

  task automatic mrw(input logic [2:0] a, input logic [7:0] d);
    start(C_MRW, {29'h0, a});
    tog(d, 1'b1);
    mr_m[a] = d;
    stop(1'b0);
  endtask

  task automatic fill(input logic [11:0] a, input int n);
    for (int k = 0; k < n; k++) begin
      wdat[k] = 8'($urandom);
      wmsk[k] = 1'b1;
    end
    wr(a, n, 1'b0);
  endtask

  initial begin
    int e0;
    logic [11:0] base;
    int len;
    for (int i = 0; i < 4096; i++) mvalid[i] = 1'b0;
    for (int i = 0; i < 8; i++) mr_m[i] = 8'h00;
    bus.psram_sck_i = 1'b0;
    bus.psram_ce_i  = 1'b1;
    bus.psram_io_i  = 8'h00;
    bus.psram_dqs_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("rst_busy", {31'h0, bus.busy_o}, 32'h0);
    chk("rst_err", {31'h0, bus.err_o}, 32'h0);
    chk("rst_io_en", {24'h0, bus.psram_io_en_o}, 32'h0);
    chk("rst_dqs_en", {31'h0, bus.psram_dqs_en_o}, 32'h0);
    chk("rst_io_o", {24'h0, bus.psram_io_o}, 32'h0);
    rst_i = 1'b0;
    repeat (3) @(negedge clk_i);

    // MR0 = 5 then read it back through 5 latency rises
    mrw(3'd0, 8'h05);
    rd(C_MRR, 12'h000, 3);

    // masked write 11,22,33 with dqs 1,0,1
    fill(12'h010, 4);
    wdat[0] = 8'h11; wdat[1] = 8'h22; wdat[2] = 8'h33;
    wmsk[0] = 1'b1;  wmsk[1] = 1'b0;  wmsk[2] = 1'b1;
    wr(12'h010, 3, 1'b0);
    rd(C_RD, 12'h010, 3);

    // wrap from top of array
    wdat[0] = 8'hAA; wdat[1] = 8'hBB; wmsk[0] = 1'b1; wmsk[1] = 1'b1;
    wr(12'hFFF, 2, 1'b0);
    rd(C_RD, 12'hFFF, 2);

    // burst cut short by ce after two bytes
    fill(12'h040, 4);
    for (int k = 0; k < 4; k++) begin
      wdat[k] = 8'hC0 + 8'(k);
      wmsk[k] = 1'b1;
    end
    wr(12'h040, 2, 1'b1);
    rd(C_RD, 12'h040, 4);

    // unknown command: one err pulse, outputs stay off in HOLD
    e0 = err_cnt;
    start(8'h77, 32'h0000_0123);
    repeat (4) @(negedge clk_i);
    chk("err_pulse", err_cnt - e0, 1);
    tog(8'h00, 1'b0);
    tog(8'h00, 1'b0);
    chk("hold_io_en", {24'h0, bus.psram_io_en_o}, 32'h0);
    chk("hold_busy", {31'h0, bus.busy_o}, 32'h1);
    stop(1'b0);
    chk("hold_err_once", err_cnt - e0, 1);
    chk("idle_busy", {31'h0, bus.busy_o}, 32'h0);

    // global reset command restores mode registers
    mrw(3'd0, 8'h09);
    start(C_RST, 32'h0);
    for (int i = 0; i < 8; i++) mr_m[i] = 8'h00;
    stop(1'b0);
    rd(C_MRR, 12'h000, 2);

    // rst_i during a read data phase
    start(C_RD, 32'h0000_0010);
    lat(mr_m[0], 1'b1);
    tog(8'h00, 1'b0);
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("midrst_io_en", {24'h0, bus.psram_io_en_o}, 32'h0);
    chk("midrst_busy", {31'h0, bus.busy_o}, 32'h0);
    rst_i = 1'b0;
    for (int i = 0; i < 8; i++) mr_m[i] = 8'h00;
    stop(1'b0);

    // randomized traffic with random latencies
    for (int it = 0; it < 24; it++) begin
      if (it % 6 == 0) begin
        mrw(3'd0, 8'($urandom_range(0, 3)));
        mrw(3'd4, 8'($urandom_range(0, 3)));
      end
      base = 12'($urandom);
      len  = $urandom_range(1, 6);
      for (int k = 0; k < len; k++) begin
        wdat[k] = 8'($urandom);
        wmsk[k] = 1'($urandom);
      end
      wr(base, len, 1'b0);
      rd(C_RD, base - 12'd1, len + 2);
      if (it % 8 == 3) rd(C_MRR, 12'($urandom_range(0, 7)), 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
